// File: rtl/dd_error_monitor_if.sv
// Purpose: bundles the symbol, decision, threshold and result signals of the DD error monitor.
// Latency: none, this is wiring only.
// Backpressure: none; the monitor accepts one symbol per clock.
// Ports: master = symbol/decision source and result sink (testbench), slave = the monitor.
interface dd_error_monitor_if #(
    parameter int IQ_WIDTH = 10
);
    localparam int MSE_W = 2*IQ_WIDTH+2;

    logic [2:0]                 psk_type;     // 001 QPSK, 010 8-PSK
    logic                       iq_val;
    logic signed [IQ_WIDTH-1:0] i_data_I;
    logic signed [IQ_WIDTH-1:0] i_data_Q;
    logic                       dec_val;
    logic signed [IQ_WIDTH-1:0] dec_I;
    logic signed [IQ_WIDTH-1:0] dec_Q;
    logic [MSE_W-1:0]           lock_thr;
    logic [MSE_W-1:0]           unlock_thr;
    logic                       err_val;
    logic signed [IQ_WIDTH:0]   err_I;
    logic signed [IQ_WIDTH:0]   err_Q;
    logic                       mse_val;
    logic [MSE_W-1:0]           mse;
    logic                       lock;

    modport master (
        output psk_type, iq_val, i_data_I, i_data_Q,
        output dec_val, dec_I, dec_Q, lock_thr, unlock_thr,
        input  err_val, err_I, err_Q, mse_val, mse, lock
    );

    modport slave (
        input  psk_type, iq_val, i_data_I, i_data_Q,
        input  dec_val, dec_I, dec_Q, lock_thr, unlock_thr,
        output err_val, err_I, err_Q, mse_val, mse, lock
    );
endinterface

// File: rtl/dd_error_monitor.sv
// Purpose: decision-directed error monitor: per-symbol error, windowed MSE, hysteretic lock flag.
// Latency: err at T+1, squared term at T+2, window result (mse_val) at T+3 of the closing symbol.
// Backpressure: none; one symbol per clock, zeroed decisions are skipped.
// Ports: clk, reset_n (async active-low), bus (dd_error_monitor_if.slave).
module dd_error_monitor #(
    parameter int IQ_WIDTH = 10,
    parameter int AVG_LOG2 = 8,
    parameter int LOCK_CNT = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    dd_error_monitor_if.slave bus
);
    localparam int ERR_W = IQ_WIDTH+1;
    localparam int MSE_W = 2*IQ_WIDTH+2;
    localparam int ACC_W = MSE_W+AVG_LOG2;
    localparam int HC_W  = $clog2(LOCK_CNT+1);
    localparam logic [HC_W-1:0]     HC_MAX   = HC_W'(LOCK_CNT);
    localparam logic [AVG_LOG2-1:0] CNT_LAST = '1;

    typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;

    // Raw-sample delay line, aligns raw symbols with the decoder output.
    logic [IQ_WIDTH-1:0] rx_i_d1_q, rx_i_d1_d, rx_q_d1_q, rx_q_d1_d;
    logic [IQ_WIDTH-1:0] rx_i_d2_q, rx_i_d2_d, rx_q_d2_q, rx_q_d2_d;
    logic                iq_val_d1_q, iq_val_d1_d, iq_val_d2_q, iq_val_d2_d;

    logic                err_val_q, err_val_d;
    logic [ERR_W-1:0]    err_i_q, err_i_d, err_q_q, err_q_d;
    logic                term_val_q, term_val_d;
    logic [MSE_W-1:0]    term_q, term_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [AVG_LOG2-1:0] cnt_q, cnt_d;
    logic                mse_val_q, mse_val_d;
    logic [MSE_W-1:0]    mse_q, mse_d;
    logic [2:0]          psk_q, psk_d;
    state_t              state_q, state_d;
    logic [HC_W-1:0]     hcnt_q, hcnt_d;
    logic                lock_q, lock_d;

    logic                     qual;
    logic                     psk_chg;
    logic                     hit;
    logic [HC_W-1:0]          hcnt_inc;
    logic signed [MSE_W-1:0]  ext_i, ext_q;
    logic [ACC_W-1:0]         acc_sum;

    // The delayed iq_val only tracks which delay-line slots carry live samples;
    // nothing downstream depends on it because the line shifts every clock.
    logic unused_iq_val;
    assign unused_iq_val = iq_val_d2_q;

    always_comb begin
        rx_i_d1_d   = bus.i_data_I;
        rx_q_d1_d   = bus.i_data_Q;
        rx_i_d2_d   = rx_i_d1_q;
        rx_q_d2_d   = rx_q_d1_q;
        iq_val_d1_d = bus.iq_val;
        iq_val_d2_d = iq_val_d1_q;

        // Stage 1: error against the decision; odd symbols decimated to (0,0) are ignored.
        qual      = bus.dec_val && ((bus.dec_I != '0) || (bus.dec_Q != '0));
        err_val_d = qual;
        err_i_d   = err_i_q;
        err_q_d   = err_q_q;
        if (qual) begin
            err_i_d = {rx_i_d2_q[IQ_WIDTH-1], rx_i_d2_q} - {bus.dec_I[IQ_WIDTH-1], bus.dec_I};
            err_q_d = {rx_q_d2_q[IQ_WIDTH-1], rx_q_d2_q} - {bus.dec_Q[IQ_WIDTH-1], bus.dec_Q};
        end

        // Stage 2: squared magnitude; max is 2*(2^IQ_WIDTH)^2 which fits MSE_W unsigned.
        ext_i      = {{(MSE_W-ERR_W){err_i_q[ERR_W-1]}}, err_i_q};
        ext_q      = {{(MSE_W-ERR_W){err_q_q[ERR_W-1]}}, err_q_q};
        term_val_d = err_val_q;
        term_d     = term_q;
        if (err_val_q) begin
            term_d = $unsigned(ext_i*ext_i + ext_q*ext_q);
        end

        // Modulation change restarts averaging and lock acquisition.
        psk_d   = bus.psk_type;
        psk_chg = (bus.psk_type != psk_q);

        // Stage 3: window accumulation; the closing term is folded straight into the result
        // so the next term opens a fresh window without losing a symbol.
        acc_sum   = acc_q + ACC_W'(term_q);
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        mse_d     = mse_q;
        mse_val_d = 1'b0;
        if (psk_chg) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (term_val_q) begin
            if (cnt_q == CNT_LAST) begin
                mse_d     = acc_sum[ACC_W-1:AVG_LOG2];
                mse_val_d = 1'b1;
                acc_d     = '0;
                cnt_d     = '0;
            end else begin
                acc_d = acc_sum;
                cnt_d = cnt_q + 1'b1;
            end
        end

        // Lock hysteresis: LOCK_CNT consecutive qualifying windows flip the state.
        state_d  = state_q;
        hcnt_d   = hcnt_q;
        hcnt_inc = hcnt_q + 1'b1;
        hit      = (state_q == UNLOCKED) ? (mse_q < bus.lock_thr) : (mse_q > bus.unlock_thr);
        if (psk_chg) begin
            state_d = UNLOCKED;
            hcnt_d  = '0;
        end else if (mse_val_q) begin
            if (!hit) begin
                hcnt_d = '0;
            end else if (hcnt_inc == HC_MAX) begin
                state_d = (state_q == UNLOCKED) ? LOCKED : UNLOCKED;
                hcnt_d  = '0;
            end else begin
                hcnt_d = hcnt_inc;
            end
        end
        lock_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_i_d1_q   <= '0;
            rx_q_d1_q   <= '0;
            rx_i_d2_q   <= '0;
            rx_q_d2_q   <= '0;
            iq_val_d1_q <= 1'b0;
            iq_val_d2_q <= 1'b0;
            err_val_q   <= 1'b0;
            err_i_q     <= '0;
            err_q_q     <= '0;
            term_val_q  <= 1'b0;
            term_q      <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            mse_val_q   <= 1'b0;
            mse_q       <= '0;
            psk_q       <= '0;
            state_q     <= UNLOCKED;
            hcnt_q      <= '0;
            lock_q      <= 1'b0;
        end else begin
            rx_i_d1_q   <= rx_i_d1_d;
            rx_q_d1_q   <= rx_q_d1_d;
            rx_i_d2_q   <= rx_i_d2_d;
            rx_q_d2_q   <= rx_q_d2_d;
            iq_val_d1_q <= iq_val_d1_d;
            iq_val_d2_q <= iq_val_d2_d;
            err_val_q   <= err_val_d;
            err_i_q     <= err_i_d;
            err_q_q     <= err_q_d;
            term_val_q  <= term_val_d;
            term_q      <= term_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            mse_val_q   <= mse_val_d;
            mse_q       <= mse_d;
            psk_q       <= psk_d;
            state_q     <= state_d;
            hcnt_q      <= hcnt_d;
            lock_q      <= lock_d;
        end
    end

    assign bus.err_val = err_val_q;
    assign bus.err_I   = err_i_q;
    assign bus.err_Q   = err_q_q;
    assign bus.mse_val = mse_val_q;
    assign bus.mse     = mse_q;
    assign bus.lock    = lock_q;
endmodule
